path_query_scheduler: RTL and testbench

- Shares one shortest-path cost engine (16-station graph, 4-bit station IDs, 4-bit cost) between NUM_REQ independent query clients.
- Arbitrates round-robin and issues one (source, destination) query at a time to the engine.
- Waits for the engine result, bounded by a timeout, and returns the cost to the granted client as a one-cycle pulse.
- Sits between client blocks and the engine's start/done interface.

---
 rtl/path_sched_pkg.sv | 17 +
 rtl/path_query_scheduler_rr_arbiter.sv | 31 +++
 rtl/path_query_scheduler.sv | 149 ++++++++++++++
 tb/tb_path_query_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_sched_pkg.sv
// Shared types and constants for the path query scheduler: FSM states,
// station/cost widths and the cost reported on an aborted query.
package path_sched_pkg;

  localparam int NODE_W = 4;
  localparam int COST_W = 4;

  localparam logic [COST_W-1:0] COST_ABORT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/path_query_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around, and reports the winner as one-hot plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!grant_any && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = k;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/path_query_scheduler.sv
// Shares one shortest-path cost engine between NUM_REQ clients: round-robin
// grant, single outstanding query, timeout abort, one-cycle response pulse.
module path_query_scheduler
  import path_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NODE_W*NUM_REQ-1:0] req_src,
  input  logic [NODE_W*NUM_REQ-1:0] req_dst,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [COST_W-1:0]         resp_cost,
  output logic                      resp_err,
  output logic                      eng_start,
  output logic [NODE_W-1:0]         eng_src,
  output logic [NODE_W-1:0]         eng_dst,
  input  logic                      eng_done,
  input  logic [COST_W-1:0]         eng_cost,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  // Abort fires on the last WAIT cycle so the error response lands exactly
  // TIMEOUT cycles after the start pulse.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NODE_W-1:0]   src_q, src_d;
  logic [NODE_W-1:0]   dst_q, dst_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    timer_q, timer_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [NODE_W-1:0]   sel_src, sel_dst;
  logic [NUM_REQ-1:0]  gid_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_src = req_src[i*NODE_W +: NODE_W];
        sel_dst = req_dst[i*NODE_W +: NODE_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cost_d    = cost_q;
    err_d     = err_q;
    timer_d   = timer_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        req_ready = arb_gnt;
        if (arb_any) begin
          gid_d  = arb_idx;
          src_d  = sel_src;
          dst_d  = sel_dst;
          cost_d = '0;
          err_d  = 1'b0;
          // A self query has cost 0 and never touches the engine.
          state_d = (sel_src == sel_dst) ? RESP : START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (eng_done) begin
          cost_d  = eng_cost;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMO_LAST) begin
          cost_d  = COST_ABORT;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cost_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cost_q  <= cost_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign gid_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gid_q;
  assign busy       = (state_q != IDLE);
  assign eng_start  = (state_q == START);
  assign eng_src    = busy ? src_q : '0;
  assign eng_dst    = busy ? dst_q : '0;
  assign resp_valid = (state_q == RESP) ? gid_oh : '0;
  assign resp_cost  = (state_q == RESP) ? cost_q : '0;
  assign resp_err   = (state_q == RESP) && err_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_path_query_scheduler.sv
// Scoreboard bench for path_query_scheduler: stimulus queues expected
// responses, engine starts and signal probes; a monitor checks them.
module tb_path_query_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 1023;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_src, req_dst;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [3:0]           resp_cost;
  logic                 resp_err;
  logic                 eng_start;
  logic [3:0]           eng_src, eng_dst;
  logic                 eng_done;
  logic [3:0]           eng_cost;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  logic auto_done, man_done;
  assign eng_done = auto_done | man_done;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic fin;
  logic eng_auto;
  int   eng_lat;
  logic [3:0] eng_cost_cfg;

  typedef enum int {K_BUSY, K_READY, K_ESRC, K_EDST, K_START,
                    K_RVALID, K_COST, K_ERR, K_GID} kind_e;
  typedef struct { int cyc; logic [3:0] vec; logic [3:0] cost; logic err; } resp_t;
  typedef struct { int cyc; logic [3:0] src; logic [3:0] dst; } start_t;
  typedef struct { int cyc; kind_e k; int ex; } probe_t;

  resp_t  rq[$];
  start_t sq[$];
  probe_t pq[$];

  path_query_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .resp_valid (resp_valid),
    .resp_cost  (resp_cost),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_src    (eng_src),
    .eng_dst    (eng_dst),
    .eng_done   (eng_done),
    .eng_cost   (eng_cost),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking side ----------------
  task automatic chk(input string nm, input int act, input int ex);
    vectors++;
    if (act != ex) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, ex);
    end
  endtask

  function automatic int sig_of(input kind_e k);
    case (k)
      K_BUSY:   return int'(busy);
      K_READY:  return int'(req_ready);
      K_ESRC:   return int'(eng_src);
      K_EDST:   return int'(eng_dst);
      K_START:  return int'(eng_start);
      K_RVALID: return int'(resp_valid);
      K_COST:   return int'(resp_cost);
      K_ERR:    return int'(resp_err);
      K_GID:    return int'(grant_id);
      default:  return -1;
    endcase
  endfunction

  initial begin : monitor
    resp_t  r;
    start_t s;
    int     idx;
    logic   fin_done;
    fin_done = 1'b0;
    forever begin
      @(negedge clk);
      idx = 0;
      while (idx < pq.size()) begin
        if (pq[idx].cyc == cyc) begin
          chk(pq[idx].k.name(), sig_of(pq[idx].k), pq[idx].ex);
          pq.delete(idx);
        end else begin
          idx++;
        end
      end
      if (resp_valid != '0) begin
        if (rq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp at cycle %0d: resp_valid=%b cost=%0d err=%0d, expected no response",
                   cyc, resp_valid, resp_cost, resp_err);
        end else begin
          r = rq.pop_front();
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_valid", int'(resp_valid), int'(r.vec));
          chk("resp_cost", int'(resp_cost), int'(r.cost));
          chk("resp_err", int'(resp_err), int'(r.err));
        end
      end
      if (eng_start) begin
        if (sq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_eng_start at cycle %0d: src=%0d dst=%0d, expected no start",
                   cyc, eng_src, eng_dst);
        end else begin
          s = sq.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("eng_src", int'(eng_src), int'(s.src));
          chk("eng_dst", int'(eng_dst), int'(s.dst));
        end
      end
      if (fin && !fin_done) begin
        chk("resp_missing", rq.size(), 0);
        chk("start_missing", sq.size(), 0);
        chk("probe_unchecked", pq.size(), 0);
        fin_done = 1'b1;
      end
    end
  end

  // ---------------- engine stub ----------------
  initial begin : engine
    auto_done = 1'b0;
    eng_cost  = '0;
    forever begin
      @(negedge clk);
      if (eng_start && eng_auto) begin
        repeat (eng_lat) @(posedge clk);
        #1;
        auto_done = 1'b1;
        eng_cost  = eng_cost_cfg;
        @(posedge clk);
        #1;
        auto_done = 1'b0;
        eng_cost  = '0;
      end
    end
  end

  // ---------------- stimulus side ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] s, input logic [3:0] d);
    req_valid[i]       = v;
    req_src[i*4 +: 4]  = s;
    req_dst[i*4 +: 4]  = d;
  endtask

  task automatic probe(input int t, input kind_e k, input int ex);
    probe_t p;
    p.cyc = t; p.k = k; p.ex = ex;
    pq.push_back(p);
  endtask

  task automatic exp_resp(input int t, input logic [3:0] v, input logic [3:0] c, input logic e);
    resp_t r;
    r.cyc = t; r.vec = v; r.cost = c; r.err = e;
    rq.push_back(r);
  endtask

  task automatic exp_start(input int t, input logic [3:0] s, input logic [3:0] d);
    start_t x;
    x.cyc = t; x.src = s; x.dst = d;
    sq.push_back(x);
  endtask

  initial begin : stim
    int c, c2, g;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_src = '0; req_dst = '0;
    man_done = 1'b0; eng_auto = 1'b1; eng_lat = 1; eng_cost_cfg = '0; fin = 1'b0;
    step(); step();

    // Reset state: every output at 0.
    c = cyc;
    for (int k = 0; k <= int'(K_GID); k++) probe(c, kind_e'(k), 0);
    step(); rst = 1'b0; step();

    // Client 2: 3 -> 9, engine answers cost 7 five cycles after start.
    c = cyc; eng_lat = 5; eng_cost_cfg = 4'd7;
    set_req(2, 1'b1, 4'd3, 4'd9);
    probe(c, K_READY, 4);
    exp_start(c + 1, 4'd3, 4'd9);
    probe(c + 4, K_ESRC, 3);
    probe(c + 4, K_EDST, 9);
    probe(c + 4, K_BUSY, 1);
    exp_resp(c + 7, 4'b0100, 4'd7, 1'b0);
    probe(c + 7, K_GID, 2);
    probe(c + 8, K_BUSY, 0);
    probe(c + 8, K_ESRC, 0);
    probe(c + 8, K_COST, 0);
    step(); set_req(2, 1'b0, 4'd0, 4'd0);
    wait_until(c + 9);

    // Client 1 self query 5 -> 5: engine bypassed.
    c = cyc;
    set_req(1, 1'b1, 4'd5, 4'd5);
    probe(c, K_READY, 2);
    exp_resp(c + 1, 4'b0010, 4'd0, 1'b0);
    probe(c + 1, K_START, 0);
    probe(c + 2, K_BUSY, 0);
    step(); set_req(1, 1'b0, 4'd0, 4'd0);
    wait_until(c + 3);

    // Stray eng_done in IDLE, then again during START of client 3's query.
    c = cyc; man_done = 1'b1;
    probe(c, K_BUSY, 0);
    step(); man_done = 1'b0;
    eng_lat = 3; eng_cost_cfg = 4'd9;
    set_req(3, 1'b1, 4'd2, 4'd4);
    probe(c + 1, K_READY, 8);
    exp_start(c + 2, 4'd2, 4'd4);
    exp_resp(c + 6, 4'b1000, 4'd9, 1'b0);
    step(); man_done = 1'b1; set_req(3, 1'b0, 4'd0, 4'd0);
    probe(c + 3, K_BUSY, 1);
    probe(c + 3, K_RVALID, 0);
    step(); man_done = 1'b0;
    wait_until(c + 8);

    // Client 0 with a silent engine: abort TIMEOUT cycles after start.
    c = cyc; eng_auto = 1'b0;
    set_req(0, 1'b1, 4'd1, 4'd2);
    probe(c, K_READY, 1);
    exp_start(c + 1, 4'd1, 4'd2);
    probe(c + 500, K_BUSY, 1);
    probe(c + TIMEOUT, K_RVALID, 0);
    exp_resp(c + 1 + TIMEOUT, 4'b0001, 4'hF, 1'b1);
    probe(c + 1 + TIMEOUT, K_GID, 0);
    step(); set_req(0, 1'b0, 4'd0, 4'd0);
    wait_until(c + TIMEOUT + 3);

    // Next service is normal: pointer now favours client 1 over client 0.
    c2 = cyc; eng_auto = 1'b1; eng_lat = 1; eng_cost_cfg = 4'd3;
    set_req(0, 1'b1, 4'd1, 4'd2);
    set_req(1, 1'b1, 4'd6, 4'd7);
    probe(c2, K_READY, 2);
    exp_start(c2 + 1, 4'd6, 4'd7);
    exp_resp(c2 + 3, 4'b0010, 4'd3, 1'b0);
    probe(c2 + 3, K_GID, 1);
    probe(c2 + 4, K_READY, 1);
    exp_start(c2 + 5, 4'd1, 4'd2);
    exp_resp(c2 + 7, 4'b0001, 4'd3, 1'b0);
    step(); set_req(1, 1'b0, 4'd0, 4'd0);
    wait_until(c2 + 5); set_req(0, 1'b0, 4'd0, 4'd0);
    wait_until(c2 + 8);

    // Reset pulsed while client 2 waits; the late eng_done must be dropped.
    c = cyc; eng_lat = 4; eng_cost_cfg = 4'd5;
    set_req(2, 1'b1, 4'd4, 4'd11);
    probe(c, K_READY, 4);
    exp_start(c + 1, 4'd4, 4'd11);
    step(); set_req(2, 1'b0, 4'd0, 4'd0);
    wait_until(c + 3); rst = 1'b1;
    probe(c + 3, K_BUSY, 0);
    probe(c + 3, K_ESRC, 0);
    probe(c + 3, K_GID, 0);
    step(); rst = 1'b0;
    probe(c + 5, K_RVALID, 0);
    probe(c + 6, K_RVALID, 0);
    wait_until(c + 7);

    // All four clients requesting: grants 0,1,2,3,0 starting from reset pointer.
    c = cyc; eng_lat = 2; eng_cost_cfg = 4'd6;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 4'(i), 4'(i + 8));
    probe(c + 2, K_READY, 0);
    for (int k = 0; k < 5; k++) begin
      g = order[k];
      probe(c + 5*k, K_READY, 1 << g);
      exp_start(c + 1 + 5*k, 4'(g), 4'(g + 8));
      exp_resp(c + 4 + 5*k, 4'(1 << g), 4'd6, 1'b0);
      probe(c + 4 + 5*k, K_GID, g);
    end
    wait_until(c + 24);
    req_valid = '0;
    wait_until(c + 27);

    fin = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
